// File: rtl/req_lru_arbiter.sv
// LRU arbiter with a single registered output stage and optional burst locking.
// The winner of a completed beat/burst moves to the tail of the priority list.
module req_lru_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter bit LOCK_EN = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
    input  logic [NUM_REQ-1:0]         req_last_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DATA_W-1:0]          out_data_o,
    output logic                       out_last_o,
    output logic [$clog2(NUM_REQ)-1:0] out_src_o,
    output logic [NUM_REQ-1:0]         grant_o
);

    localparam int IW = $clog2(NUM_REQ);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [IW-1:0]     order_q [NUM_REQ];
    logic [IW-1:0]     order_d [NUM_REQ];
    logic [0:0]        state_q, state_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic [IW-1:0]     out_src_q, out_src_d;

    logic               cand_vld;
    logic [IW-1:0]      cand_idx;
    logic [NUM_REQ-1:0] cand_oh;
    logic [DATA_W-1:0]  cand_data;
    logic               cand_last;
    logic               load;
    logic               accept;
    logic               hit;

    always_comb begin
        cand_vld  = 1'b0;
        cand_idx  = '0;
        cand_oh   = '0;
        cand_data = '0;
        cand_last = 1'b0;
        if (state_q == ST_LOCKED) begin
            cand_vld = req_valid_i[owner_q];
            cand_idx = owner_q;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!cand_vld && req_valid_i[order_q[k]]) begin
                    cand_vld = 1'b1;
                    cand_idx = order_q[k];
                end
            end
        end
        // No candidate may be presented while reset is held.
        cand_vld = cand_vld & rst_n;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == cand_idx) begin
                cand_oh[i] = cand_vld;
                cand_data  = req_data_i[i*DATA_W +: DATA_W];
                cand_last  = req_last_i[i];
            end
        end
    end

    assign load        = !out_valid_q || out_ready_i;
    assign accept      = load && cand_vld;
    assign req_ready_o = load ? cand_oh : '0;
    assign grant_o     = cand_oh;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        state_d     = state_q;
        owner_d     = owner_q;
        order_d     = order_q;
        hit         = 1'b0;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = cand_data;
            out_last_d  = cand_last;
            out_src_d   = cand_idx;
            if (LOCK_EN && !cand_last) begin
                state_d = ST_LOCKED;
                owner_d = cand_idx;
            end else begin
                state_d = ST_IDLE;
                // Winner goes to the tail; everything behind it moves up one slot.
                for (int unsigned k = 0; k < NUM_REQ - 1; k++) begin
                    if (order_q[k] == cand_idx) begin
                        hit = 1'b1;
                    end
                    if (hit) begin
                        order_d[k] = order_q[k+1];
                    end
                end
                order_d[NUM_REQ-1] = cand_idx;
            end
        end else if (load) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                order_q[k] <= IW'(k);
            end
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else begin
            order_q     <= order_d;
            state_q     <= state_d;
            owner_q     <= owner_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign out_src_o   = out_src_q;

endmodule

// File: tb/tb_req_lru_arbiter.sv
// Self-checking bench for req_lru_arbiter: directed scenarios plus a random
// phase, all compared against a queue-based LRU reference model.
module tb_req_lru_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic [IW-1:0]   out_src;
    logic [N-1:0]    grant;

    req_lru_arbiter #(.NUM_REQ(N), .DATA_W(DW), .LOCK_EN(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_src_o   (out_src),
        .grant_o     (grant)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: priority list as a queue, head = highest priority.
    int            ord[$];
    bit            m_locked;
    int            m_owner;
    bit            m_valid;
    logic [DW-1:0] m_data;
    bit            m_last;
    int            m_src;
    int            e_cand;
    bit            e_load;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ord = {0, 1, 2, 3};
        m_locked = 1'b0;
        m_owner  = 0;
        m_valid  = 1'b0;
        m_data   = '0;
        m_last   = 1'b0;
        m_src    = 0;
    endtask

    task automatic model_comb();
        e_cand = -1;
        if (rst_n) begin
            if (m_locked) begin
                if (req_valid[m_owner]) e_cand = m_owner;
            end else begin
                foreach (ord[k]) if (e_cand < 0 && req_valid[ord[k]]) e_cand = ord[k];
            end
        end
        e_load = !m_valid || out_ready;
    endtask

    task automatic model_update();
        int idx;
        if (!rst_n) begin
            model_reset();
        end else if (e_load && e_cand >= 0) begin
            m_valid = 1'b1;
            m_data  = req_data[e_cand*DW +: DW];
            m_last  = req_last[e_cand];
            m_src   = e_cand;
            if (req_last[e_cand]) begin
                idx = 0;
                foreach (ord[k]) if (ord[k] == e_cand) idx = k;
                ord.delete(idx);
                ord.push_back(e_cand);
                m_locked = 1'b0;
            end else begin
                m_locked = 1'b1;
                m_owner  = e_cand;
            end
        end else if (e_load) begin
            m_valid = 1'b0;
        end
    endtask

    // Called at a negedge with inputs settled; returns at the next negedge.
    task automatic cycle(input string tag);
        logic [31:0] exp_g;
        #1;
        model_comb();
        exp_g = (e_cand >= 0) ? (32'd1 << e_cand) : 32'd0;
        chk({tag, ":grant"}, 32'(grant), exp_g);
        chk({tag, ":ready"}, 32'(req_ready), e_load ? exp_g : 32'd0);
        chk({tag, ":ready_onehot0"}, 32'($onehot0(req_ready)), 32'd1);
        @(posedge clk);
        model_update();
        #1;
        chk({tag, ":out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ":out_data"}, 32'(out_data), 32'(m_data));
        chk({tag, ":out_last"}, 32'(out_last), 32'(m_last));
        chk({tag, ":out_src"}, 32'(out_src), 32'(m_src));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle("reset");
        cycle("reset");
        rst_n = 1'b1;
    endtask

    int sp_exp[4] = '{0, 2, 0, 2};

    initial begin
        model_reset();
        req_valid = '0;
        req_last  = '0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 16'h1000 + 16'(i);
        @(negedge clk);

        // Reset with all valids set, then round robin from src 0.
        req_valid = '1;
        req_last  = '1;
        rst_n = 1'b0;
        cycle("rst");
        cycle("rst");
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        #1 chk("first_grant", 32'(grant), 32'h1);
        for (int i = 0; i < 5; i++) begin
            cycle("rr");
            chk("rr_src", 32'(out_src), 32'(i % 4));
            chk("rr_data", 32'(out_data), 32'h1000 + 32'(i % 4));
        end

        // Sparse requesters 0 and 2.
        do_reset();
        req_valid = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            cycle("sparse");
            chk("sparse_src", 32'(out_src), 32'(sp_exp[i]));
        end

        // Locked burst from src1 with a valid gap; src0 must wait.
        do_reset();
        req_valid = 4'b0010; req_last = 4'b0000;
        cycle("lock");
        chk("lock_b1_src", 32'(out_src), 32'd1);
        req_valid = 4'b0011; req_last = 4'b0001;
        cycle("lock");
        chk("lock_b2_src", 32'(out_src), 32'd1);
        req_valid = 4'b0001;
        #1 chk("lock_gap_grant", 32'(grant), 32'd0);
        cycle("lock");
        chk("lock_gap_bubble", 32'(out_valid), 32'd0);
        req_valid = 4'b0011; req_last = 4'b0011;
        cycle("lock");
        chk("lock_b3_src", 32'(out_src), 32'd1);
        chk("lock_b3_last", 32'(out_last), 32'd1);
        req_valid = 4'b0001;
        cycle("lock");
        chk("lock_after_src", 32'(out_src), 32'd0);

        // Backpressure holds the stored beat.
        do_reset();
        req_valid = '1; req_last = '1; out_ready = 1'b1;
        cycle("bp");
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_ready_zero", 32'(req_ready), 32'd0);
            cycle("bp");
            chk("bp_src_stable", 32'(out_src), 32'd0);
            chk("bp_data_stable", 32'(out_data), 32'h1000);
        end
        out_ready = 1'b1;
        cycle("bp");
        chk("bp_next_src", 32'(out_src), 32'd1);
        chk("bp_next_data", 32'(out_data), 32'h1001);

        // Reset in the middle of a src3 burst.
        do_reset();
        req_valid = 4'b1000; req_last = 4'b0000;
        cycle("rmb");
        cycle("rmb");
        do_reset();
        chk("rmb_out_valid", 32'(out_valid), 32'd0);
        req_valid = '1; req_last = '1;
        for (int i = 0; i < 4; i++) begin
            cycle("rmb");
            chk("rmb_src", 32'(out_src), 32'(i));
        end

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rst_n     = ($urandom_range(0, 39) != 0);
            req_valid = N'($urandom);
            for (int r = 0; r < N; r++) begin
                req_last[r] = ($urandom_range(0, 2) == 0);
                req_data[r*DW +: DW] = DW'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/req_lru_arbiter.md
REQ_LRU_ARBITER -- requirements
Module: req_lru_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (legal range 2 to 16).
REQ-002 SHALL have parameter DATA_W, default 16, request payload width.
REQ-003 SHALL have parameter LOCK_EN, default 1; when 1, a grant is held from the first beat through the last beat of a burst.
REQ-004 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports: req_valid_i  in  NUM_REQ  per-requester valid; req_data_i  in  NUM_REQ*DATA_W  packed payloads, requester i at bits [i*DATA_W +: DATA_W]; req_last_i  in  NUM_REQ  per-requester last-beat flag.
REQ-006 SHALL have port: req_ready_o  out  NUM_REQ  per-requester accept, at most one bit set.
REQ-007 SHALL have ports: out_valid_o  out  1; out_ready_i  in  1; out_data_o  out  DATA_W; out_last_o  out  1; out_src_o  out  $clog2(NUM_REQ)  index of the source of the beat.
REQ-008 SHALL have port: grant_o  out  NUM_REQ  one-hot current winner candidate, zero when no candidate exists.

Function
REQ-009 SHALL keep an LRU priority list order[0..NUM_REQ-1]; order[0] has the highest priority.
REQ-010 SHALL select as candidate the first order[k] with req_valid_i set (IDLE), or the lock owner if its valid is set (LOCKED).
REQ-011 SHALL define load = !out_valid_o || out_ready_i, so the single output register accepts a beat when it is empty or draining.
REQ-012 SHALL assert req_ready_o[candidate] combinationally when load=1 and a candidate exists; all other bits SHALL be 0.
REQ-013 SHALL, on an accepted beat, register data, last and source index into out_data_o/out_last_o/out_src_o and set out_valid_o on the next edge (1-cycle latency, 1 beat/cycle throughput).
REQ-014 SHALL clear out_valid_o on the next edge when load=1 and no candidate exists.
REQ-015 SHALL hold out_* stable and keep req_ready_o all-zero while out_valid_o=1 and out_ready_i=0.
REQ-016 SHALL, on an accepted beat with (LOCK_EN=0 or last=1), move the winner to order[NUM_REQ-1] and shift the entries behind it up by one; entries ahead of it are unchanged.
REQ-017 SHALL not update order on an accepted non-last beat when LOCK_EN=1.
REQ-018 SHALL have states IDLE and LOCKED; IDLE->LOCKED on an accepted beat with last=0 and LOCK_EN=1, recording the owner; LOCKED->IDLE on the owner's accepted last beat.
REQ-019 SHALL, in LOCKED, grant no other requester even if the owner deasserts valid; bubbles are inserted instead.
REQ-020 SHALL, when the LOCKED->IDLE transition and the LRU update fall on the same edge, base the next arbitration on the updated order.
REQ-021 SHALL drive grant_o to one-hot(candidate) regardless of load.

Reset
REQ-022 SHALL, with rst_n=0 at a clk edge, set order[i]=i, state=IDLE, and out_valid_o, out_last_o, out_data_o and out_src_o to 0.
REQ-023 SHALL abandon any lock or in-flight output beat on a reset asserted mid-burst; no recovery of the lost beat is required.
REQ-024 SHALL keep req_ready_o and grant_o at 0 while rst_n=0.

Verification
REQ-025 Reset: hold rst_n=0 for 2 cycles with all valids set -> all outputs 0, and the first grant after release goes to src 0.
REQ-026 Round robin: N=4, all valid, last=1, out_ready=1, data=0x1000+i -> out_src 0,1,2,3,0 on consecutive cycles with out_data=0x1000+src.
REQ-027 Sparse: only src 0 and 2 valid, last=1 -> out_src 0,2,0,2; order after the first grant is 1,2,3,0.
REQ-028 Lock: src1 sends a 3-beat burst (last on beat 3) with src0 valid from cycle 1 -> out_src 1,1,1,0; inject a 1-cycle src1 valid gap -> bubble, src0 not granted.
REQ-029 Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data and out_src stable, req_ready_o=0; on release the stored beat drains, then the next beat issues.
REQ-030 Reset mid-burst: rst_n=0 after beat 2 of a src3 burst -> state IDLE, out_valid_o=0, and the next grant follows order 0,1,2,3.
